// File: rtl/apb_pkg.sv
// Shared constants and types for the APB master bridge.
// Address map, slave indices and the bridge FSM state encoding.
package apb_pkg;

    localparam int unsigned NUM_SLAVES = 4;

    localparam logic [15:0] APB_REGION_BASE = 16'h1000;

    localparam int unsigned IDX_MSB = 15;
    localparam int unsigned IDX_LSB = 12;

    localparam int unsigned GPO_IDX   = 0;
    localparam int unsigned GPI_IDX   = 1;
    localparam int unsigned TIMER_IDX = 2;
    localparam int unsigned UART_IDX  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    function automatic logic [3:0] slave_idx(input logic [31:0] a);
        return a[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder.
// Maps a CPU byte address to a one-hot slave select plus a miss flag.
module apb_addr_decoder
    import apb_pkg::*;
(
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  miss
);

    logic [3:0] idx;
    logic       hit;

    // Region match on the upper half, then index range check and one-hot expand
    always_comb begin
        idx  = slave_idx(addr);
        hit  = (addr[31:16] == APB_REGION_BASE)
            && (32'(idx) < NUM_SLAVES);
        sel  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = hit && (32'(idx) == i);
        end
        miss = !hit;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB3 master bridge with 4 slave selects.
// Runs IDLE/SETUP/ACCESS and bounds the wait with a timeout error.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    apb_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic        miss_q, miss_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic        dec_miss;
    logic [NUM_SLAVES-1:0] pready_vec;
    logic [31:0] prdata_arr [NUM_SLAVES];
    logic        pready_sel;
    logic [31:0] prdata_sel;
    logic        done;
    logic [NUM_SLAVES-1:0] psel;

    apb_addr_decoder u_dec (
        .addr (addr),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};
    assign prdata_arr[0] = PRDATA0;
    assign prdata_arr[1] = PRDATA1;
    assign prdata_arr[2] = PRDATA2;
    assign prdata_arr[3] = PRDATA3;

    // Return-path mux: only the latched select may reach the CPU side
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                pready_sel = pready_sel | pready_vec[i];
                prdata_sel = prdata_sel | prdata_arr[i];
            end
        end
    end

    // Next-state logic: latch in IDLE, one SETUP, wait in ACCESS
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        sel_d    = sel_q;
        miss_d   = miss_q;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwrite_d = write;
                    pwdata_d = wdata;
                    sel_d    = dec_sel;
                    miss_d   = dec_miss;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                done = miss_q || pready_sel || (cnt_q == TO_LAST);
                if (done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CPU response is combinational in the completing ACCESS cycle
    always_comb begin
        ready = done;
        err   = done && (miss_q || !pready_sel);
        rdata = '0;
        if (done && pready_sel && !pwrite_q) begin
            rdata = prdata_sel;
        end
    end

    // APB control: selects live through SETUP and ACCESS
    always_comb begin
        psel    = (state_q != IDLE) ? sel_q : '0;
        PENABLE = (state_q == ACCESS);
    end

    assign PSEL0  = psel[0];
    assign PSEL1  = psel[1];
    assign PSEL2  = psel[2];
    assign PSEL3  = psel[3];
    assign PADDR  = paddr_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;

    // State and latched request registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            sel_q    <= '0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            sel_q    <= sel_d;
            miss_q   <= miss_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge.
// Table vectors, hand sequences and randomized transfers vs a reference model.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        transfer, write;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    int total = 0;
    int bad = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1),
        .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1),
        .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    // Slave models: slave 0 is a GPO register block with registered PREADY,
    // slaves 1..3 answer after slat ACCESS cycles with srd. Unselected
    // slaves drive junk to prove the return mux ignores them.
    logic [3:0]  psel;
    int          acnt;
    int          slat;
    logic [31:0] srd;
    logic [3:0]  junk_rdy;
    logic [31:0] junk_rd;
    logic [31:0] gpo_regs [4];
    logic [31:0] gpo_shadow [4];

    assign psel = {PSEL3, PSEL2, PSEL1, PSEL0};

    always @(posedge PCLK) begin
        acnt <= (|psel && PENABLE) ? acnt + 1 : 0;
    end

    assign PREADY0 = psel[0] ? (PENABLE && acnt >= 1) : junk_rdy[0];
    assign PREADY1 = psel[1] ? (PENABLE && acnt >= slat) : junk_rdy[1];
    assign PREADY2 = psel[2] ? (PENABLE && acnt >= slat) : junk_rdy[2];
    assign PREADY3 = psel[3] ? (PENABLE && acnt >= slat) : junk_rdy[3];
    assign PRDATA0 = psel[0] ? gpo_regs[PADDR[3:2]] : junk_rd;
    assign PRDATA1 = psel[1] ? srd : ~junk_rd;
    assign PRDATA2 = psel[2] ? srd : junk_rd ^ 32'h5a5a5a5a;
    assign PRDATA3 = psel[3] ? srd : junk_rd + 32'd1;

    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < 4; i++) gpo_regs[i] <= '0;
        end else if (PSEL0 && PENABLE && PREADY0 && PWRITE) begin
            gpo_regs[PADDR[3:2]] <= PWDATA;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one request from the current (IDLE) cycle and watch it complete.
    // CPU inputs other than transfer are scrambled after the IDLE cycle.
    task automatic do_xfer(input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input bit keep,
                           output int cyc, output logic [31:0] rd,
                           output logic e, output logic [3:0] mask,
                           output int pen, output bit stab);
        transfer = 1'b1;
        addr = a;
        write = w;
        wdata = wd;
        cyc = -1;
        rd = '0;
        e = 1'b0;
        mask = '0;
        pen = 0;
        stab = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            mask = mask | psel;
            if (PENABLE) pen++;
            if (k > 0 && (PADDR !== a || PWRITE !== w || PWDATA !== wd))
                stab = 1'b0;
            if (ready) begin
                cyc = k;
                rd = rdata;
                e = err;
                break;
            end
            @(posedge PCLK);
            #1;
            addr = $urandom;
            wdata = $urandom;
            write = 1'($urandom);
        end
        @(posedge PCLK);
        #1;
        if (!keep) transfer = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [31:0] a,
                             input logic w, input logic [31:0] wd,
                             input bit keep, input int ec, input logic ee,
                             input logic [31:0] er, input logic [3:0] em);
        int cyc, pen;
        logic [31:0] rd;
        logic e;
        logic [3:0] mask;
        bit stab;
        do_xfer(a, w, wd, keep, cyc, rd, e, mask, pen, stab);
        chk({nm, "_cyc"}, cyc, ec);
        chk({nm, "_err"}, {31'd0, e}, {31'd0, ee});
        chk({nm, "_rdata"}, rd, er);
        chk({nm, "_psel"}, {28'd0, mask}, {28'd0, em});
        chk({nm, "_penable_cycles"}, pen, ec - 1);
        chk({nm, "_stable"}, {31'd0, stab}, 32'd1);
        chk({nm, "_idle_after"}, {27'd0, PENABLE, psel}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        int          ec;
        logic        ee;
        logic [31:0] er;
        logic [3:0]  em;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lats [9];
        transfer = 1'b0;
        write = 1'b0;
        addr = '0;
        wdata = '0;
        slat = 0;
        srd = '0;
        junk_rdy = '0;
        junk_rd = '0;
        for (int i = 0; i < 4; i++) gpo_shadow[i] = '0;
        lats = '{0, 1, 2, 3, 5, 14, 15, 16, 255};

        vecs[0] = '{32'h1000_2000, 1'b0, 32'h0, 0, 32'hDEAD_BEEF,
                    2, 1'b0, 32'hDEAD_BEEF, 4'b0100};
        vecs[1] = '{32'h1000_1008, 1'b0, 32'h0, 3, 32'h1234_5678,
                    5, 1'b0, 32'h1234_5678, 4'b0010};
        vecs[2] = '{32'h1000_3000, 1'b1, 32'h0BAD_F00D, 0, 32'hFFFF_FFFF,
                    2, 1'b0, 32'h0, 4'b1000};
        vecs[3] = '{32'h2000_0000, 1'b0, 32'h0, 0, 32'h1111_1111,
                    2, 1'b1, 32'h0, 4'b0000};
        vecs[4] = '{32'h1000_4000, 1'b0, 32'h0, 0, 32'h2222_2222,
                    2, 1'b1, 32'h0, 4'b0000};
        vecs[5] = '{32'h1001_1000, 1'b1, 32'h77, 0, 32'h3333_3333,
                    2, 1'b1, 32'h0, 4'b0000};
        vecs[6] = '{32'h1000_3010, 1'b0, 32'h0, 15, 32'hA5A5_0F0F,
                    17, 1'b0, 32'hA5A5_0F0F, 4'b1000};
        vecs[7] = '{32'h1000_3000, 1'b0, 32'h0, 16, 32'h4444_4444,
                    17, 1'b1, 32'h0, 4'b1000};
        vecs[8] = '{32'h1000_1000, 1'b1, 32'h99, 255, 32'h5555_5555,
                    17, 1'b1, 32'h0, 4'b0010};
        vecs[9] = '{32'h1000_2004, 1'b1, 32'hCAFE, 2, 32'h6666_6666,
                    4, 1'b0, 32'h0, 4'b0100};

        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_psel", {28'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        chk("rst_resp", {30'd0, ready, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;

        junk_rdy = 4'b1110;
        junk_rd = 32'h1357_9BDF;
        run_check("gpo_wr", 32'h1000_0004, 1'b1, 32'hA5, 1'b0,
                  3, 1'b0, 32'h0, 4'b0001);
        chk("gpo_reg1", gpo_regs[1], 32'hA5);
        gpo_shadow[1] = 32'hA5;

        for (int i = 0; i < 10; i++) begin
            slat = vecs[i].lat;
            srd = vecs[i].rd;
            junk_rdy = 4'($urandom);
            junk_rd = $urandom;
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].w,
                      vecs[i].wd, 1'b0, vecs[i].ec, vecs[i].ee,
                      vecs[i].er, vecs[i].em);
        end

        junk_rdy = 4'b1110;
        run_check("b2b_cr", 32'h1000_0000, 1'b1, 32'hFF, 1'b1,
                  3, 1'b0, 32'h0, 4'b0001);
        run_check("b2b_odr", 32'h1000_0004, 1'b1, 32'h3C, 1'b0,
                  3, 1'b0, 32'h0, 4'b0001);
        chk("b2b_reg0", gpo_regs[0], 32'hFF);
        chk("b2b_gpo", gpo_regs[1], 32'h3C);
        gpo_shadow[0] = 32'hFF;
        gpo_shadow[1] = 32'h3C;

        slat = 255;
        junk_rdy = '0;
        transfer = 1'b1;
        addr = 32'h1000_1000;
        write = 1'b0;
        wdata = '0;
        repeat (3) @(negedge PCLK);
        chk("prerst_sel", {27'd0, PENABLE, psel}, {27'd0, 5'b10010});
        #2;
        PRESET = 1'b0;
        transfer = 1'b0;
        #1;
        chk("rst_mid_sel", {27'd0, PENABLE, psel}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_paddr", PADDR, 32'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        for (int i = 0; i < 4; i++) gpo_shadow[i] = '0;
        slat = 0;
        srd = 32'hCAFE_F00D;
        run_check("post_rst", 32'h1000_1000, 1'b0, 32'h0, 1'b0,
                  2, 1'b0, 32'hCAFE_F00D, 4'b0010);

        for (int n = 0; n < 60; n++) begin
            int kind, idx, lat, ec;
            logic [31:0] a, wd, er;
            logic w, ee;
            logic [3:0] em;
            bit keep;
            kind = $urandom_range(0, 2);
            w = 1'($urandom);
            wd = $urandom;
            keep = (n != 59) && ($urandom_range(0, 3) == 0);
            junk_rdy = 4'($urandom);
            junk_rd = $urandom;
            srd = $urandom;
            if (kind == 0) begin
                idx = $urandom_range(0, 3);
                a = 32'h1000_0000 + 32'(idx * 4);
                ec = 3;
                ee = 1'b0;
                er = w ? 32'h0 : gpo_shadow[idx];
                em = 4'b0001;
                if (w) gpo_shadow[idx] = wd;
            end else if (kind == 1) begin
                idx = $urandom_range(1, 3);
                lat = lats[$urandom_range(0, 8)];
                slat = lat;
                a = {16'h1000, 4'(idx), 12'($urandom)};
                em = 4'(1 << idx);
                if (lat <= 15) begin
                    ec = 2 + lat;
                    ee = 1'b0;
                    er = w ? 32'h0 : srd;
                end else begin
                    ec = 17;
                    ee = 1'b1;
                    er = 32'h0;
                end
            end else begin
                a = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    a[31:16] = 16'h1000;
                    a[15:12] = 4'($urandom_range(4, 15));
                end else if (a[31:16] == 16'h1000) begin
                    a[31:16] = 16'hFFFF;
                end
                ec = 2;
                ee = 1'b1;
                er = 32'h0;
                em = 4'b0000;
            end
            run_check($sformatf("rnd%0d", n), a, w, wd, keep,
                      ec, ee, er, em);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
